// File: rtl/mwadd_seq_if.sv
// Request/result bundle between a requester and the mwadd_seq add sequencer.
// With MWADD_SUB_EN defined the bundle also carries the subtract select.
interface mwadd_seq_if #(
    parameter int N     = 8,
    parameter int WORDS = 4
);
    localparam int W = N * WORDS;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef MWADD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

`ifdef MWADD_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/mwadd_seq.sv
// Multi-precision adder: one W-bit add time-shared over a single N-bit ripple slice,
// least-significant word first. Optional subtract mode under macro MWADD_SUB_EN.
module nrca #(
    parameter int N = 8
) (
    output logic [N-1:0] sum,
    output logic         cout,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin
);
    logic [N:0] c;

    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < N; k++) begin
            sum[k]   = a[k] ^ b[k] ^ c[k];
            c[k+1]   = (a[k] & b[k]) | (a[k] & c[k]) | (b[k] & c[k]);
        end
        cout = c[N];
    end
endmodule

module mwadd_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    mwadd_seq_if.slave  bus
);
    localparam int W  = N * WORDS;
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [N-1:0]  op_a, op_b, slice_sum;
    logic          slice_cout;

    assign op_a = a_q[idx_q*N +: N];
    assign op_b = b_q[idx_q*N +: N];

    nrca #(.N(N)) u_slice (
        .sum  (slice_sum),
        .cout (slice_cout),
        .a    (op_a),
        .b    (op_b),
        .cin  (carry_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
`ifdef MWADD_SUB_EN
                    // a - b == a + ~b + 1; cout then reads as "no borrow".
                    if (bus.sub) begin
                        b_d     = ~bus.b;
                        carry_d = 1'b1;
                    end
`endif
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*N +: N] = slice_sum;
                carry_d             = slice_cout;
                // Stop at the last word instead of incrementing so the index never wraps.
                if (idx_q == LAST) begin
                    cout_d  = slice_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_mwadd_seq.sv
// Self-checking bench for mwadd_seq: directed cases plus randomized operands
// checked against a plain-arithmetic reference.
module tb_mwadd_seq;
    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    mwadd_seq_if #(.N(N), .WORDS(WORDS)) bus ();

    mwadd_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: {cout, sum} = a + b + cin, or a - b with cout = no-borrow.
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
        logic [W:0] r;
        if (sub) begin
            r[W-1:0] = a - b;
            r[W]     = (a >= b);
        end else begin
            r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        end
        return r;
    endfunction

    task automatic drive_sub(input logic s);
`ifdef MWADD_SUB_EN
        bus.sub = s;
`else
        if (s) $display("note: sub requested without subtract support");
`endif
    endtask

    // Pulse start, scramble inputs after acceptance, wait (bounded) for done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, output logic [W-1:0] rs, output logic rc,
                         output int lat, output int busy_low);
        int k;
        bus.a = a; bus.b = b; bus.cin = c; drive_sub(s);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
        drive_sub(1'($urandom));
        k = 0; busy_low = 0; lat = -1;
        while (k < 50) begin
            @(negedge clk);
            if (!bus.busy) busy_low++;
            if (bus.done) begin lat = k; break; end
            @(posedge clk); #1;
            k++;
        end
        rs = bus.sum; rc = bus.cout;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b1; bus.a = 32'h1234_5678; bus.b = 32'h1; bus.cin = 1'b1;
        drive_sub(1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.sum !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h want 00000000", bus.sum); end
        n_cmp++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", bus.cout); end
        @(posedge clk); #1;
        bus.start = 1'b0; rst = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_nostart: busy %b want 0", bus.busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [W-1:0] rs; logic rc; int lat, bl;
        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, rs, rc, lat, bl);
        n_cmp++; if (lat !== WORDS) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, WORDS); end
        n_cmp++; if (bl !== 0) begin n_fail++; $display("FAIL basic_busy: busy low %0d cycles want 0", bl); end
        n_cmp++; if (rs !== 32'h0000_0100) begin n_fail++; $display("FAIL basic_sum: got %h want 00000100", rs); end
        n_cmp++; if (rc !== 1'b0) begin n_fail++; $display("FAIL basic_cout: got %b want 0", rc); end
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_after: done %b busy %b want 0 0", bus.done, bus.busy); end
        n_cmp++; if (bus.sum !== 32'h0000_0100) begin n_fail++; $display("FAIL basic_hold: got %h want 00000100", bus.sum); end
        @(posedge clk); #1;
    endtask

    task automatic test_ripple();
        logic [W-1:0] rs; logic rc; int lat, bl;
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, rs, rc, lat, bl);
        n_cmp++; if (rs !== 32'h0) begin n_fail++; $display("FAIL ripple_sum: got %h want 00000000", rs); end
        n_cmp++; if (rc !== 1'b1) begin n_fail++; $display("FAIL ripple_cout: got %b want 1", rc); end
        do_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, rs, rc, lat, bl);
        n_cmp++; if (rs !== 32'h2345_678A) begin n_fail++; $display("FAIL cin_sum: got %h want 2345678a", rs); end
        n_cmp++; if (rc !== 1'b0) begin n_fail++; $display("FAIL cin_cout: got %b want 0", rc); end
    endtask

    task automatic test_ignored_start();
        int k, dones, first_done;
        logic [W-1:0] rs; logic rc;
        bus.a = 32'hA5A5_0F0F; bus.b = 32'h0101_F0F1; bus.cin = 1'b0; drive_sub(1'b0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.a = 32'h1111_1111; bus.b = 32'h2222_2222; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones = 0; first_done = -1; rs = '0; rc = 1'b0;
        for (k = 0; k < 14; k++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                if (first_done < 0) begin first_done = k; rs = bus.sum; rc = bus.cout; end
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL ignore_dones: got %0d want 1", dones); end
        n_cmp++; if ({rc, rs} !== ref_op(32'hA5A5_0F0F, 32'h0101_F0F1, 1'b0, 1'b0)) begin
            n_fail++; $display("FAIL ignore_result: got %b_%h want %h", rc, rs, ref_op(32'hA5A5_0F0F, 32'h0101_F0F1, 1'b0, 1'b0)); end
    endtask

    task automatic test_back_to_back();
        int k, dones, last, bad_gap, bad_res;
        logic [W:0] exp;
        exp = ref_op(32'h8000_0010, 32'h8000_0020, 1'b1, 1'b0);
        bus.a = 32'h8000_0010; bus.b = 32'h8000_0020; bus.cin = 1'b1; drive_sub(1'b0);
        bus.start = 1'b1;
        dones = 0; last = -1; bad_gap = 0; bad_res = 0;
        for (k = 0; k < 32; k++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                if (last >= 0 && (k - last) != WORDS + 2) bad_gap++;
                if ({bus.cout, bus.sum} !== exp) bad_res++;
                last = k;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        n_cmp++; if (dones !== 5) begin n_fail++; $display("FAIL b2b_count: got %0d want 5", dones); end
        n_cmp++; if (bad_gap !== 0) begin n_fail++; $display("FAIL b2b_spacing: %0d bad gaps want 0", bad_gap); end
        n_cmp++; if (bad_res !== 0) begin n_fail++; $display("FAIL b2b_result: %0d bad results want 0", bad_res); end
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            if (!bus.busy) break;
            @(posedge clk); #1;
            k++;
        end
        n_cmp++; if (k >= 10) begin n_fail++; $display("FAIL b2b_drain: busy stuck %b want 0", bus.busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int k, dones;
        logic [W-1:0] rs; logic rc; int lat, bl;
        bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.cin = 1'b1; drive_sub(1'b0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.sum !== 32'h0 || bus.cout !== 1'b0) begin n_fail++; $display("FAIL midrst_clear: got %b_%h want 0_00000000", bus.cout, bus.sum); end
        dones = 0;
        for (k = 0; k < 8; k++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL midrst_done: got %0d pulses want 0", dones); end
        @(posedge clk); #1;
        do_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, rs, rc, lat, bl);
        n_cmp++; if (rs !== 32'h0000_0007 || rc !== 1'b0) begin n_fail++; $display("FAIL midrst_next: got %b_%h want 0_00000007", rc, rs); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, rs; logic c, s, rc; int lat, bl;
        logic [W:0] exp;
        for (int i = 0; i < 24; i++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            if (i == 0) begin a = '1; b = '1; c = 1'b1; end
            if (i == 1) begin a = '0; b = '0; c = 1'b0; end
            s = 1'b0;
`ifdef MWADD_SUB_EN
            s = 1'($urandom);
`endif
            exp = ref_op(a, b, c, s);
            do_op(a, b, c, s, rs, rc, lat, bl);
            n_cmp++;
            if ({rc, rs} !== exp || lat !== WORDS || bl !== 0) begin
                n_fail++;
                $display("FAIL random_%0d: got %b_%h lat %0d busylow %0d want %b_%h lat %0d", i, rc, rs, lat, bl, exp[W], exp[W-1:0], WORDS);
            end
        end
    endtask

`ifdef MWADD_SUB_EN
    task automatic test_sub();
        logic [W-1:0] rs; logic rc; int lat, bl;
        do_op(32'd5, 32'd7, 1'b0, 1'b1, rs, rc, lat, bl);
        n_cmp++; if (rs !== 32'hFFFF_FFFE || rc !== 1'b0) begin n_fail++; $display("FAIL sub_borrow: got %b_%h want 0_fffffffe", rc, rs); end
        do_op(32'd7, 32'd5, 1'b0, 1'b1, rs, rc, lat, bl);
        n_cmp++; if (rs !== 32'h0000_0002 || rc !== 1'b1) begin n_fail++; $display("FAIL sub_noborrow: got %b_%h want 1_00000002", rc, rs); end
    endtask
`endif

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        drive_sub(1'b0);
        test_reset();
        test_basic();
        test_ripple();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef MWADD_SUB_EN
        test_sub();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
